// File: rtl/mux_select_sequencer_pkg.sv
// Shared types and constants for the 4-channel mux select sequencer.
// The MUX_SEQ_MASK_EN build option adds a channel enable mask on the top module.
package mux_select_sequencer_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef logic [CH_W-1:0]   ch_t;
  typedef logic [NUM_CH-1:0] mask_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_PRESENT
  } state_t;

endpackage

// File: rtl/mux_select_sequencer_if.sv
// Tagged sample stream (valid/ready) leaving the mux select sequencer.
interface mux_select_sequencer_if #(
  parameter int N = 4
);
  import mux_select_sequencer_pkg::*;

  logic [N-1:0] out_data;
  ch_t          out_ch;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_data, output out_ch, output out_valid, input out_ready);
  modport slave  (input out_data, input out_ch, input out_valid, output out_ready);

endinterface

// File: rtl/mux_select_sequencer_next_ch.sv
// Rotating-priority picker: nearest enabled channel after cur, wrapping modulo NUM_CH.
module mux_select_sequencer_next_ch
  import mux_select_sequencer_pkg::*;
(
  input  ch_t   cur,
  input  mask_t mask,
  output ch_t   next,
  output logic  wrap,
  output logic  none
);

  ch_t cand;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    next = cur;
    cand = cur;
    none = (mask == '0);
    // Scan farthest to nearest so the nearest enabled candidate wins.
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = cur + ch_t'(i);
      if (mask[cand]) next = cand;
    end
    wrap = !none && (next <= cur);
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// Scans mux select 0..3, waits dwell cycles per channel, then presents {channel, data}.
// Define MUX_SEQ_MASK_EN to add the ch_mask port; otherwise all four channels are scanned.
module mux_select_sequencer
  import mux_select_sequencer_pkg::*;
#(
  parameter int N       = 4,
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic [N-1:0]         y_in,
  output ch_t                  sel,
  output logic                 frame_done,
  output logic                 busy,
  mux_select_sequencer_if.master stream
`ifdef MUX_SEQ_MASK_EN
  ,
  input  mask_t                ch_mask
`endif
);

  state_t             state, state_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  ch_t                sel_nxt;
  logic [N-1:0]       data_nxt;
  ch_t                ch_nxt;
  logic               valid_nxt;
  logic               frame_done_nxt;
  logic               busy_nxt;

  mask_t mask;
  ch_t   pick_cur;
  ch_t   pick_next;
  logic  pick_wrap;
  logic  pick_none;

`ifdef MUX_SEQ_MASK_EN
  assign mask = ch_mask;
`else
  assign mask = '1;
`endif

  // Starting from the last channel makes the picker return the lowest enabled one.
  assign pick_cur = (state == ST_IDLE) ? ch_t'(NUM_CH - 1) : sel;

  mux_select_sequencer_next_ch u_next_ch (
    .cur  (pick_cur),
    .mask (mask),
    .next (pick_next),
    .wrap (pick_wrap),
    .none (pick_none)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (run && !pick_none) state_nxt = ST_SETTLE;
      ST_SETTLE:
        if (!run)              state_nxt = ST_IDLE;
        else if (cnt == dwell) state_nxt = ST_PRESENT;
      ST_PRESENT:
        if (stream.out_ready)  state_nxt = (run && !pick_none) ? ST_SETTLE : ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt        = cnt;
    sel_nxt        = sel;
    data_nxt       = stream.out_data;
    ch_nxt         = stream.out_ch;
    valid_nxt      = stream.out_valid;
    frame_done_nxt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (run && !pick_none) begin
          sel_nxt = pick_next;
          cnt_nxt = '0;
        end
      end
      ST_SETTLE: begin
        if (run) begin
          if (cnt == dwell) begin
            data_nxt  = y_in;
            ch_nxt    = sel;
            valid_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + DWELL_W'(1);
          end
        end
      end
      ST_PRESENT: begin
        if (stream.out_ready) begin
          valid_nxt      = 1'b0;
          frame_done_nxt = pick_wrap;
          if (run && !pick_none) begin
            sel_nxt = pick_next;
            cnt_nxt = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign busy_nxt = (state_nxt != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt              <= '0;
      sel              <= '0;
      stream.out_data  <= '0;
      stream.out_ch    <= '0;
      stream.out_valid <= 1'b0;
      frame_done       <= 1'b0;
      busy             <= 1'b0;
    end else begin
      cnt              <= cnt_nxt;
      sel              <= sel_nxt;
      stream.out_data  <= data_nxt;
      stream.out_ch    <= ch_nxt;
      stream.out_valid <= valid_nxt;
      frame_done       <= frame_done_nxt;
      busy             <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer; the mux is modelled as y_in = sel + 1.
module tb_mux_select_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [7:0] dwell;
  logic [3:0] y_in;
  logic [1:0] sel;
  logic       frame_done;
  logic       busy;
`ifdef MUX_SEQ_MASK_EN
  logic [3:0] ch_mask;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  mux_select_sequencer_if #(.N(4)) stream ();

  mux_select_sequencer #(.N(4), .DWELL_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .dwell      (dwell),
    .y_in       (y_in),
    .sel        (sel),
    .frame_done (frame_done),
    .busy       (busy),
    .stream     (stream.master)
`ifdef MUX_SEQ_MASK_EN
    ,
    .ch_mask    (ch_mask)
`endif
  );

  assign y_in = 4'(sel) + 4'd1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    dwell = 8'd0;
    stream.out_ready = 1'b1;
`ifdef MUX_SEQ_MASK_EN
    ch_mask = 4'b1111;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts negedges until out_valid is seen, plus frame_done pulses on the way.
  task automatic wait_valid(input int max, output int n, output int fd);
    n = 0;
    fd = 0;
    do begin
      @(negedge clk);
      n++;
      if (frame_done) fd++;
    end while (!stream.out_valid && n < max);
  endtask

  task automatic check_sample(input string tag, input int n, input int fd,
                              input int exp_n, input int exp_ch, input int exp_fd);
    tests_run++;
    if (stream.out_valid !== 1'b1 || n !== exp_n) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d valid=%b, expected %0d", tag, n, stream.out_valid, exp_n);
    end
    tests_run++;
    if (stream.out_ch !== 2'(exp_ch) || sel !== 2'(exp_ch)) begin
      tests_failed++;
      $display("FAIL %s channel: got ch=%0d sel=%0d, expected %0d", tag, stream.out_ch, sel, exp_ch);
    end
    tests_run++;
    if (stream.out_data !== 4'(exp_ch + 1)) begin
      tests_failed++;
      $display("FAIL %s data: got %0d, expected %0d", tag, stream.out_data, exp_ch + 1);
    end
    tests_run++;
    if (fd !== exp_fd) begin
      tests_failed++;
      $display("FAIL %s frame_done: got %0d pulses, expected %0d", tag, fd, exp_fd);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run = 1'b0;
    dwell = 8'd0;
    stream.out_ready = 1'b1;
`ifdef MUX_SEQ_MASK_EN
    ch_mask = 4'b1111;
`endif
    #1;
    tests_run++;
    if ({sel, stream.out_ch, stream.out_data, stream.out_valid, frame_done, busy} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset: got sel=%0d ch=%0d data=%0d valid=%b fd=%b busy=%b, expected all 0",
               sel, stream.out_ch, stream.out_data, stream.out_valid, frame_done, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scan_dwell3();
    int n, fd;
    int exp_ch[5] = '{0, 1, 2, 3, 0};
    int exp_fd[5] = '{0, 0, 0, 0, 1};
    do_reset();
    dwell = 8'd3;
    run = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL scan3 busy: got %b, expected 1", busy);
    end
    // One cycle already spent above, so the first sample needs 4 more.
    wait_valid(20, n, fd);
    check_sample("scan3[0]", n + 1, fd, 5, exp_ch[0], exp_fd[0]);
    for (int i = 1; i < 5; i++) begin
      wait_valid(20, n, fd);
      check_sample($sformatf("scan3[%0d]", i), n, fd, 5, exp_ch[i], exp_fd[i]);
    end
  endtask

  task automatic test_dwell0();
    int n, fd;
    int exp_fd[5] = '{0, 0, 0, 0, 1};
    do_reset();
    dwell = 8'd0;
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(10, n, fd);
      check_sample($sformatf("dwell0[%0d]", i), n, fd, 2, i % 4, exp_fd[i]);
    end
  endtask

  task automatic test_backpressure();
    int n, fd, bad;
    do_reset();
    dwell = 8'd3;
    run = 1'b1;
    wait_valid(20, n, fd);
    check_sample("bp ch0", n, fd, 5, 0, 0);
    wait_valid(20, n, fd);
    check_sample("bp ch1", n, fd, 5, 1, 0);
    stream.out_ready = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (stream.out_valid !== 1'b1 || stream.out_data !== 4'd2 || stream.out_ch !== 2'd1 ||
          sel !== 2'd1 || frame_done !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL bp stall: got %0d unstable cycles, expected 0", bad);
    end
    stream.out_ready = 1'b1;
    wait_valid(20, n, fd);
    check_sample("bp ch2", n, fd, 5, 2, 0);
  endtask

  task automatic test_run_drop();
    int n, fd, bad;
    do_reset();
    dwell = 8'd3;
    run = 1'b1;
    wait_valid(20, n, fd);
    wait_valid(20, n, fd);
    check_sample("drop ch1", n, fd, 5, 1, 0);
    @(negedge clk);
    tests_run++;
    if (sel !== 2'd2 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop settle: got sel=%0d busy=%b, expected 2/1", sel, busy);
    end
    run = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || stream.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop idle: got busy=%b valid=%b, expected 0/0", busy, stream.out_valid);
    end
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (stream.out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL drop abort: got %0d emitting cycles, expected 0", bad);
    end
    run = 1'b1;
    wait_valid(20, n, fd);
    check_sample("drop restart", n, fd, 5, 0, 0);
    run = 1'b0;
    stream.out_ready = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (stream.out_valid !== 1'b1 || stream.out_ch !== 2'd0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL drop pending: got %0d dropped cycles, expected 0", bad);
    end
    stream.out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (stream.out_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop delivered: got valid=%b busy=%b fd=%b, expected 0/0/0",
               stream.out_valid, busy, frame_done);
    end
  endtask

  task automatic test_async_reset();
    int n, fd;
    do_reset();
    dwell = 8'd3;
    run = 1'b1;
    wait_valid(20, n, fd);
    wait_valid(20, n, fd);
    check_sample("arst ch1", n, fd, 5, 1, 0);
    stream.out_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (stream.out_valid !== 1'b0 || sel !== 2'd0 || busy !== 1'b0 || stream.out_data !== 4'd0) begin
      tests_failed++;
      $display("FAIL arst: got valid=%b sel=%0d busy=%b data=%0d, expected 0/0/0/0",
               stream.out_valid, sel, busy, stream.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b0;
    stream.out_ready = 1'b1;
  endtask

`ifdef MUX_SEQ_MASK_EN
  task automatic test_mask();
    int n, fd;
    int exp_ch[5] = '{1, 3, 1, 3, 1};
    int exp_fd[5] = '{0, 0, 1, 0, 1};
    do_reset();
    ch_mask = 4'b1010;
    dwell = 8'd0;
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(10, n, fd);
      check_sample($sformatf("mask[%0d]", i), n, fd, 2, exp_ch[i], exp_fd[i]);
    end
    ch_mask = 4'b0000;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || stream.out_valid !== 1'b0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mask empty: got busy=%b valid=%b fd=%b, expected 0/0/0",
               busy, stream.out_valid, frame_done);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan_dwell3();
    test_dwell0();
    test_backpressure();
    test_run_drop();
    test_async_reset();
`ifdef MUX_SEQ_MASK_EN
    test_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
